// File: rtl/con_flag_bank_pkg.sv
// con_pkg: condition codes shared by the flag bank, its evaluator and the bench
package con_pkg;
  typedef logic [2:0] cond_code_t;
  localparam cond_code_t COND_EQZ    = 3'd0;
  localparam cond_code_t COND_NEZ    = 3'd1;
  localparam cond_code_t COND_GEZ    = 3'd2;
  localparam cond_code_t COND_LTZ    = 3'd3;
  localparam cond_code_t COND_GTZ    = 3'd4;
  localparam cond_code_t COND_LEZ    = 3'd5;
  localparam cond_code_t COND_ALWAYS = 3'd6;
  localparam cond_code_t COND_NEVER  = 3'd7;
endpackage

// File: rtl/con_flag_bank_if.sv
// con_flag_bank_if: strobe/operand/read bus between control and the flag bank
interface con_flag_bank_if
  import con_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int CHANNELS = 4,
  parameter int SEL_W    = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) ();
  logic                con_in;
  cond_code_t          cond_code;
  logic [SEL_W-1:0]    wr_sel;
  logic [DATA_W-1:0]   bus_data;
  logic                con_clr;
  logic [SEL_W-1:0]    rd_sel;
  logic [CHANNELS-1:0] con_q;
  logic                con_out;
  logic [CHANNELS-1:0] con_pending;
  modport master (
    output con_in, cond_code, wr_sel, bus_data, con_clr, rd_sel,
    input  con_q, con_out, con_pending
  );
  modport slave (
    input  con_in, cond_code, wr_sel, bus_data, con_clr, rd_sel,
    output con_q, con_out, con_pending
  );
endinterface

// File: rtl/con_flag_bank_eval.sv
// con_eval: combinational signed-zero condition test of one operand
module con_eval
  import con_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [DATA_W-1:0] data_i,
  input  cond_code_t        code_i,
  output logic              res_o
);
  logic zero, neg;
  logic [7:0] tbl;
  assign zero = (data_i == '0);
  assign neg  = data_i[DATA_W-1];
  // indexed by code: NEVER, ALWAYS, LEZ, GTZ, LTZ, GEZ, NEZ, EQZ
  assign tbl   = {1'b0, 1'b1, neg | zero, ~neg & ~zero, neg, ~neg, ~zero, zero};
  assign res_o = tbl[code_i];
endmodule

// File: rtl/con_flag_bank.sv
// con_flag_bank: two-stage condition evaluation latched into per-channel flags
module con_flag_bank
  import con_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int CHANNELS = 4,
  parameter int SEL_W    = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input logic            clk,
  input logic            reset,
  con_flag_bank_if.slave bus
);
  logic                s1_valid_q;
  logic [DATA_W-1:0]   s1_data_q;
  cond_code_t          s1_code_q;
  logic [SEL_W-1:0]    s1_sel_q;
  logic [CHANNELS-1:0] con_q_q, con_q_d, pending;
  logic                res;
  con_eval #(.DATA_W(DATA_W)) u_eval (
    .data_i (s1_data_q),
    .code_i (s1_code_q),
    .res_o  (res)
  );
  // out-of-range selects never match a channel, so they write nothing
  always_comb begin
    pending = '0;
    con_q_d = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      pending[c] = s1_valid_q && (s1_sel_q == SEL_W'(c));
      con_q_d[c] = pending[c] ? res : (con_q_q[c] & ~bus.con_clr);
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid_q <= 1'b0;
      s1_data_q  <= '0;
      s1_code_q  <= COND_EQZ;
      s1_sel_q   <= '0;
      con_q_q    <= '0;
    end else begin
      s1_valid_q <= bus.con_in;
      con_q_q    <= con_q_d;
      if (bus.con_in) begin
        s1_data_q <= bus.bus_data;
        s1_code_q <= bus.cond_code;
        s1_sel_q  <= bus.wr_sel;
      end
    end
  end
  assign bus.con_q       = con_q_q;
  assign bus.con_pending = pending;
  assign bus.con_out     = |(con_q_q & (CHANNELS'(1) << bus.rd_sel));
endmodule

// File: tb/tb_con_flag_bank.sv
// tb_con_flag_bank: random + directed checks of the flag bank against a behavioural model
module tb_con_flag_bank;
  import con_pkg::*;
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;
  con_flag_bank_if #(.DATA_W(32), .CHANNELS(4)) bus ();
  con_flag_bank #(.DATA_W(32), .CHANNELS(4)) dut (.clk(clk), .reset(reset), .bus(bus));
  con_flag_bank_if #(.DATA_W(8), .CHANNELS(1)) sb ();
  con_flag_bank #(.DATA_W(8), .CHANNELS(1)) dut1 (.clk(clk), .reset(reset), .bus(sb));
  int vectors = 0;
  int miscompares = 0;
  function automatic logic ref_eval(logic [2:0] code, logic [31:0] d);
    logic signed [31:0] v;
    v = d;
    case (code)
      3'd0: return v == 0;
      3'd1: return v != 0;
      3'd2: return v >= 0;
      3'd3: return v < 0;
      3'd4: return v > 0;
      3'd5: return v <= 0;
      3'd6: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction
  logic [3:0]  m_flags = '0;
  logic        m_pv = 1'b0;
  logic [2:0]  m_code = '0;
  logic [31:0] m_data = '0;
  logic [1:0]  m_sel = '0;
  logic        m_live = 1'b0;
  function automatic logic [3:0] next_flags();
    logic [3:0] f;
    f = bus.con_clr ? 4'b0 : m_flags;
    if (m_pv) f[m_sel] = ref_eval(m_code, m_data);
    return f;
  endfunction
  always @(posedge clk) begin
    if (reset) begin
      m_flags <= '0;
      m_pv    <= 1'b0;
      m_live  <= 1'b1;
    end else begin
      m_flags <= next_flags();
      m_pv    <= bus.con_in;
      if (bus.con_in) begin
        m_code <= bus.cond_code;
        m_data <= bus.bus_data;
        m_sel  <= bus.wr_sel;
      end
    end
  end
  always @(negedge clk) begin
    logic       exp_out;
    logic [3:0] exp_pend;
    if (m_live) begin
      exp_out  = m_flags[bus.rd_sel];
      exp_pend = m_pv ? (4'(1) << m_sel) : 4'b0;
      vectors++;
      if (bus.con_q !== m_flags || bus.con_out !== exp_out || bus.con_pending !== exp_pend) begin
        miscompares++;
        $display("FAIL model t=%0t con_q=%b exp %b con_out=%b exp %b pending=%b exp %b",
                 $time, bus.con_q, m_flags, bus.con_out, exp_out, bus.con_pending, exp_pend);
      end
    end
  end
  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic strobe(logic [2:0] code, int sel, logic [31:0] d);
    bus.con_in    = 1'b1;
    bus.cond_code = code;
    bus.wr_sel    = 2'(sel);
    bus.bus_data  = d;
    step();
    bus.con_in = 1'b0;
  endtask
  task automatic set_all();
    for (int i = 0; i < 4; i++) strobe(COND_ALWAYS, i, 32'h0);
    step();
    chk("set_all", 32'(bus.con_q), 32'hF);
  endtask
  task automatic strobe1(logic [2:0] code, logic sel, logic [7:0] d);
    sb.con_in    = 1'b1;
    sb.cond_code = code;
    sb.wr_sel    = sel;
    sb.bus_data  = d;
    step();
    sb.con_in = 1'b0;
  endtask
  logic [31:0] dv [4] = '{32'h0, 32'h1, 32'h8000_0000, 32'h7FFF_FFFF};
  logic [3:0]  lit [8] = '{4'b0001, 4'b1110, 4'b1011, 4'b0100, 4'b1010, 4'b0101, 4'b1111, 4'b0000};
  initial begin
    bus.con_in = 0; bus.cond_code = '0; bus.wr_sel = '0; bus.bus_data = '0;
    bus.con_clr = 0; bus.rd_sel = '0;
    sb.con_in = 0; sb.cond_code = '0; sb.wr_sel = '0; sb.bus_data = '0;
    sb.con_clr = 0; sb.rd_sel = '0;
    step();
    step();
    reset = 1'b0;
    chk("reset_q", 32'(bus.con_q), 32'h0);
    chk("reset_out", 32'(bus.con_out), 32'h0);
    chk("reset_pend", 32'(bus.con_pending), 32'h0);
    for (int c = 0; c < 8; c++)
      for (int i = 0; i < 4; i++) begin
        strobe(3'(c), 0, dv[i]);
        step();
        chk($sformatf("code%0d_d%0d", c, i), 32'(bus.con_out), 32'(lit[c][i]));
      end
    bus.rd_sel = 2'd2;
    strobe(COND_LTZ, 2, 32'hFFFF_FFFF);
    chk("ltz_pend", 32'(bus.con_pending), 32'h4);
    step();
    chk("ltz_pend_off", 32'(bus.con_pending), 32'h0);
    chk("ltz_q", 32'(bus.con_q), 32'h4);
    chk("ltz_out", 32'(bus.con_out), 32'h1);
    for (int i = 0; i < 4; i++) strobe(COND_EQZ, i, (i % 2) != 0 ? 32'd5 : 32'd0);
    step();
    chk("b2b_q", 32'(bus.con_q), 32'h5);
    set_all();
    strobe(COND_NEVER, 1, 32'h0);
    bus.con_clr = 1'b1;
    step();
    bus.con_clr = 1'b0;
    chk("clr_never", 32'(bus.con_q), 32'h0);
    set_all();
    strobe(COND_ALWAYS, 3, 32'h0);
    bus.con_clr = 1'b1;
    step();
    bus.con_clr = 1'b0;
    chk("clr_always", 32'(bus.con_q), 32'h8);
    strobe(COND_NEZ, 0, 32'd7);
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("rst_mid_q", 32'(bus.con_q), 32'h0);
    chk("rst_mid_pend", 32'(bus.con_pending), 32'h0);
    step();
    chk("rst_mid_q2", 32'(bus.con_q), 32'h0);
    strobe1(COND_GTZ, 1'b0, 8'h7F);
    step();
    chk("w8_gtz_7f", 32'(sb.con_out), 32'h1);
    strobe1(COND_GTZ, 1'b0, 8'h80);
    step();
    chk("w8_gtz_80", 32'(sb.con_out), 32'h0);
    strobe1(COND_GTZ, 1'b0, 8'h00);
    step();
    chk("w8_gtz_00", 32'(sb.con_out), 32'h0);
    strobe1(COND_ALWAYS, 1'b0, 8'h00);
    step();
    chk("w8_set", 32'(sb.con_q), 32'h1);
    strobe1(COND_NEVER, 1'b1, 8'h00);
    chk("w8_oor_pend", 32'(sb.con_pending), 32'h0);
    step();
    chk("w8_oor_q", 32'(sb.con_q), 32'h1);
    for (int n = 0; n < 600; n++) begin
      int pick;
      pick = $urandom_range(0, 4);
      bus.con_in    = $urandom_range(0, 3) != 0;
      bus.cond_code = 3'($urandom_range(0, 7));
      bus.wr_sel    = 2'($urandom_range(0, 3));
      bus.bus_data  = pick < 4 ? dv[pick] : $urandom;
      if ($urandom_range(0, 5) == 0) bus.bus_data = 32'hFFFF_FFFF;
      bus.con_clr   = $urandom_range(0, 7) == 0;
      bus.rd_sel    = 2'($urandom_range(0, 3));
      reset         = $urandom_range(0, 63) == 0;
      step();
    end
    bus.con_in = 1'b0;
    bus.con_clr = 1'b0;
    reset = 1'b0;
    step();
    step();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
